// File: rtl/exec_sched_if.sv
// Request/response bundle between the front-end requesters and the operation scheduler.
// Requester fields are packed {r1, r0}.
interface exec_sched_if;
    logic [1:0]   req_valid;
    logic [1:0]   req_ready;
    logic [5:0]   req_unit;
    logic [5:0]   req_op;
    logic [3:0]   req_size;
    logic [127:0] req_opa;
    logic [127:0] req_opb;
    logic [1:0]   rsp_valid;
    logic [63:0]  rsp_data;
    logic         rsp_err;
    logic         busy;

    modport master (
        output req_valid, req_unit, req_op, req_size, req_opa, req_opb,
        input  req_ready, rsp_valid, rsp_data, rsp_err, busy
    );

    modport slave (
        input  req_valid, req_unit, req_op, req_size, req_opa, req_opb,
        output req_ready, rsp_valid, rsp_data, rsp_err, busy
    );
endinterface

// File: rtl/exec_sched.sv
// Round-robin scheduler sharing the execution units and a 4-entry value store
// between the console (requester 0) and the UART path (requester 1).
//
// state | meaning
// IDLE  | arbitrate, accept one request, register masked operands
// ISSUE | operands on the bus; fetch/store/invalid resolve here
// WAIT  | count integer latency or wait for fpu_ready / timeout
// RESP  | one-cycle response strobe to the granted requester
module exec_sched #(
    parameter int INT_LAT     = 2,
    parameter int FPU_TIMEOUT = 255
) (
    input  logic         clk,
    input  logic         rst,
    exec_sched_if.slave  bus,
    output logic [2:0]   ex_op,
    output logic [63:0]  ex_opa,
    output logic [63:0]  ex_opb,
    output logic         fpu_start,
    input  logic         fpu_ready,
    input  logic [63:0]  fp_out,
    input  logic [63:0]  bit_manip_out,
    input  logic [63:0]  int_calc_out,
    input  logic [63:0]  int_logic_out
);

    localparam int CNT_MAX = (FPU_TIMEOUT > INT_LAT) ? FPU_TIMEOUT : INT_LAT;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] INT_LAT_C = CW'(INT_LAT);
    localparam logic [CW-1:0] FPU_TO_C  = CW'(FPU_TIMEOUT);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t        state;
    logic          grant_r;
    logic          last_grant;
    logic [2:0]    unit_r;
    logic [CW-1:0] cnt;
    logic [63:0]   store [4];
    logic [1:0]    rsp_valid_r;
    logic [63:0]   rsp_data_r;
    logic          rsp_err_r;

    logic          any_req;
    logic          gnt;
    logic [1:0]    ready_c;
    logic [1:0]    grant_oh;
    logic [2:0]    sel_unit;
    logic [2:0]    sel_op;
    logic [1:0]    sel_size;
    logic [63:0]   sel_opa;
    logic [63:0]   sel_opb;

    function automatic logic [63:0] size_mask(input logic [63:0] v, input logic [1:0] sz);
        case (sz)
            2'd0:    return {48'd0, v[15:0]};
            2'd1:    return {32'd0, v[31:0]};
            default: return v;
        endcase
    endfunction

    // On a tie the requester that was not served last wins.
    always_comb begin
        any_req  = |bus.req_valid;
        gnt      = (&bus.req_valid) ? ~last_grant : bus.req_valid[1];
        sel_unit = gnt ? bus.req_unit[5:3]   : bus.req_unit[2:0];
        sel_op   = gnt ? bus.req_op[5:3]     : bus.req_op[2:0];
        sel_size = gnt ? bus.req_size[3:2]   : bus.req_size[1:0];
        sel_opa  = gnt ? bus.req_opa[127:64] : bus.req_opa[63:0];
        sel_opb  = gnt ? bus.req_opb[127:64] : bus.req_opb[63:0];
        ready_c  = 2'b00;
        if (state == IDLE && any_req) begin
            ready_c = gnt ? 2'b10 : 2'b01;
        end
        grant_oh = grant_r ? 2'b10 : 2'b01;
    end

    assign bus.req_ready = ready_c;
    assign bus.rsp_valid = rsp_valid_r;
    assign bus.rsp_data  = rsp_data_r;
    assign bus.rsp_err   = rsp_err_r;
    assign bus.busy      = (state != IDLE);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= IDLE;
            grant_r     <= 1'b0;
            last_grant  <= 1'b1;
            unit_r      <= 3'd0;
            cnt         <= '0;
            ex_op       <= 3'd0;
            ex_opa      <= 64'd0;
            ex_opb      <= 64'd0;
            fpu_start   <= 1'b0;
            rsp_valid_r <= 2'b00;
            rsp_data_r  <= 64'd0;
            rsp_err_r   <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                store[i] <= 64'd0;
            end
        end else begin
            fpu_start   <= 1'b0;
            rsp_valid_r <= 2'b00;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        grant_r   <= gnt;
                        unit_r    <= sel_unit;
                        ex_op     <= sel_op;
                        ex_opa    <= size_mask(sel_opa, sel_size);
                        ex_opb    <= size_mask(sel_opb, sel_size);
                        fpu_start <= (sel_unit == 3'd0);
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    cnt <= CW'(1);
                    case (unit_r)
                        3'd0, 3'd1, 3'd2, 3'd3: state <= WAIT;
                        3'd4: begin
                            rsp_data_r  <= store[ex_op[1:0]];
                            rsp_err_r   <= 1'b0;
                            rsp_valid_r <= grant_oh;
                            state       <= RESP;
                        end
                        3'd5: begin
                            store[ex_op[1:0]] <= ex_opa;
                            rsp_data_r  <= ex_opa;
                            rsp_err_r   <= 1'b0;
                            rsp_valid_r <= grant_oh;
                            state       <= RESP;
                        end
                        default: begin
                            rsp_data_r  <= 64'd0;
                            rsp_err_r   <= 1'b1;
                            rsp_valid_r <= grant_oh;
                            state       <= RESP;
                        end
                    endcase
                end
                WAIT: begin
                    if (unit_r == 3'd0) begin
                        // A ready on the timeout cycle still counts as a completion.
                        if (fpu_ready) begin
                            rsp_data_r  <= fp_out;
                            rsp_err_r   <= 1'b0;
                            rsp_valid_r <= grant_oh;
                            state       <= RESP;
                        end else if (cnt == FPU_TO_C) begin
                            rsp_data_r  <= 64'd0;
                            rsp_err_r   <= 1'b1;
                            rsp_valid_r <= grant_oh;
                            state       <= RESP;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end else if (cnt == INT_LAT_C) begin
                        case (unit_r)
                            3'd1:    rsp_data_r <= bit_manip_out;
                            3'd2:    rsp_data_r <= int_calc_out;
                            default: rsp_data_r <= int_logic_out;
                        endcase
                        rsp_err_r   <= 1'b0;
                        rsp_valid_r <= grant_oh;
                        state       <= RESP;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                RESP: begin
                    last_grant <= grant_r;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/exec_sched.md
# exec_sched

Operation scheduler that shares the execution datapath (fpu_double, int_bit_manip, int_calc, int_log) and a 4-entry 64-bit value store between two requesters: the switch console FSM (requester 0) and the UART command path (requester 1). It arbitrates round-robin, masks operands to the selected size, drives the shared operand/opcode bus, waits on the FPU ready flag or on a fixed integer latency, and returns one result per accepted request. It sits between the front-end FSMs and the execution units in the top-level wrapper.

## Interface
Parameters:
- INT_LAT, 2: cycles from issue to valid output for int_bit_manip / int_calc / int_log.
- FPU_TIMEOUT, 255: max WAIT cycles for fpu_ready before the error response.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous, active-low reset.
- req_valid  in  2  per-requester request (bit0 console, bit1 UART).
- req_ready  out  2  one-cycle accept strobe, combinational from state/grant.
- req_unit  in  6  {r1,r0} unit select: 0 FPU, 1 bit-manip, 2 calc, 3 logic, 4 fetch, 5 store, 6-7 invalid.
- req_op  in  6  {r1,r0} unit opcode; for fetch/store op[1:0] = store index.
- req_size  in  4  {r1,r0} 0: 16-bit, 1: 32-bit, 2/3: 64-bit.
- req_opa, req_opb  in  128 each  {r1,r0} operands.
- ex_op  out  3  opcode to all units.
- ex_opa, ex_opb  out  64 each  masked operands to all units.
- fpu_start  out  1  one-cycle start pulse to fpu_double.
- fpu_ready  in  1  fpu_double completion.
- fp_out, bit_manip_out, int_calc_out, int_logic_out  in  64 each  unit results.
- rsp_valid  out  2  one-cycle response strobe to the granted requester.
- rsp_data  out  64  result, valid while rsp_valid != 0.
- rsp_err  out  1  invalid unit or FPU timeout, qualified by rsp_valid.
- busy  out  1  high in any state except IDLE.

## Operation
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE: if any req_valid, grant g; both valid -> requester != last_grant. req_ready[g]=1 this cycle; payload captured at the edge. Operands zero-extended from [15:0] (size 0), [31:0] (size 1), full (size 2/3). -> ISSUE.
- Handshake: transfer only on req_valid[i] & req_ready[i]. Requester holds payload until accepted; dropping req_valid before grant withdraws the request.
- ISSUE: ex_op/ex_opa/ex_opb driven (registered, held through WAIT, retain last value afterwards). Unit 0: fpu_start=1 -> WAIT. Units 1-3 -> WAIT. Unit 4: result=store[op[1:0]]. Unit 5: store[op[1:0]]<=opa, result=opa. Units 4/5 -> RESP. Unit 6/7: result=0, err=1 -> RESP.
- WAIT, units 1-3: counter 1..INT_LAT; on count==INT_LAT capture the selected unit output -> RESP.
- WAIT, unit 0: fpu_ready ignored in ISSUE; first WAIT cycle with fpu_ready=1 captures fp_out -> RESP. Counter reaching FPU_TIMEOUT without ready: result=0, err=1 -> RESP.
- RESP: rsp_valid[g]=1, rsp_data/rsp_err driven; last_grant<=g -> IDLE. rsp_valid otherwise 0.

## Timing
- Reset (rst=0 at edge): state IDLE, req_ready=0, rsp_valid=0, rsp_data=0, rsp_err=0, fpu_start=0, ex_op/ex_opa/ex_opb=0, busy=0, last_grant=1 (console wins first tie), store cleared, counter 0.
- Accept at cycle T. ISSUE T+1 (fpu_start high T+1 only). Fetch/store/invalid: rsp_valid at T+2. Int units: rsp_valid at T+2+INT_LAT. FPU: fpu_ready first seen at T+1+k (k>=1) -> rsp_valid at T+2+k; timeout -> rsp_valid at T+2+FPU_TIMEOUT.
- req_ready low in ISSUE/WAIT/RESP; next accept earliest the cycle after RESP.
- Reset mid-operation: operation abandoned, no rsp_valid, store cleared.
- Fetch of an index stored by the immediately preceding request returns the new value.

## Test plan
- Reset, then r0 store: unit 5, op 2, size 2, opa 0x0123_4567_89AB_CDEF -> req_ready[0] at T, rsp_valid[0] at T+2, rsp_data 0x0123456789ABCDEF; r1 fetch op 2 returns the same.
- r0 and r1 valid same cycle, unit 2 both, INT_LAT=2 -> r0 accepted first, rsp_valid[0] at T+4; r1 accepted T+5, rsp_valid[1] at T+9; repeat tie -> r0 again only after r1 served.
- r0 unit 2, size 0, opa 0xFFFF_FFFF_0001_0005 -> ex_opa = 0x0000_0000_0000_0005 during ISSUE/WAIT.
- r1 unit 0, fpu_ready stub high 5 cycles after fpu_start -> fpu_start single pulse at T+1, rsp_valid[1] at T+7 with fp_out value, rsp_err 0.
- FPU_TIMEOUT=8, fpu_ready tied 0 -> rsp_valid at T+10, rsp_data 0, rsp_err 1; unit 7 -> rsp_err 1 at T+2.
- rst=0 during WAIT -> no rsp_valid, busy 0 next cycle, fetch of a previously stored index returns 0.
